// File: rtl/gen_demux_pkg.sv
// Shared types and constants for the registered stream demultiplexer family.
// Holds the lock-state encoding, route constants and the route-to-lock helper.
package gen_demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic ROUTE_OUT0 = 1'b0;
    localparam logic ROUTE_OUT1 = 1'b1;

    // Lock state entered when a multi-beat packet starts on the given route.
    function automatic state_t lock_state(input logic route);
        return (route == ROUTE_OUT1) ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/gen_demux_slot.sv
// One-entry register stage for {data, last} with a valid flag.
// A load wins over a drain in the same cycle, so valid stays set with the new beat.
module gen_demux_slot #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gen_demux2_reg.sv
// Registered 1-to-2 stream demultiplexer with packet-level route locking.
// The FSM pins the route for the remainder of a packet once its first beat is accepted.
module gen_demux2_reg
    import gen_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             busy
);

    state_t state_q;
    state_t state_d;
    logic   route;
    logic   accept;
    logic   load0;
    logic   load1;
    logic   route_valid;
    logic   route_ready;

    always_comb begin
        route = in_sel;
        unique case (state_q)
            IDLE:    route = in_sel;
            LOCK0:   route = ROUTE_OUT0;
            LOCK1:   route = ROUTE_OUT1;
            default: route = in_sel;
        endcase
    end

    // in_ready depends only on slot occupancy and the routed downstream ready.
    always_comb begin
        route_valid = (route == ROUTE_OUT1) ? out1_valid : out0_valid;
        route_ready = (route == ROUTE_OUT1) ? out1_ready : out0_ready;
        in_ready    = reset_n && (!route_valid || route_ready);
    end

    assign accept = in_valid && in_ready;
    assign load0  = accept && (route == ROUTE_OUT0);
    assign load1  = accept && (route == ROUTE_OUT1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d = lock_state(in_sel);
                end
            end
            LOCK0, LOCK1: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q != IDLE);

    gen_demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load0),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_ready (out0_ready),
        .out_valid (out0_valid),
        .out_data  (out0_data),
        .out_last  (out0_last)
    );

    gen_demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load1),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_ready (out1_ready),
        .out_valid (out1_valid),
        .out_data  (out1_data),
        .out_last  (out1_last)
    );

endmodule

// File: tb/tb_gen_demux2_reg.sv
// Directed self-checking bench for gen_demux2_reg (WIDTH = 8).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after that.
module tb_gen_demux2_reg;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_sel;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out0_data;
    logic         out0_last;
    logic         out1_valid;
    logic         out1_ready;
    logic [W-1:0] out1_data;
    logic         out1_last;
    logic         busy;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    gen_demux2_reg #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d, input logic l);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 8'hA5;
        in_last    = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        tick();
        tick();
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_out1_last", out1_last, 0);
        chk("rst_busy", busy, 0);

        // Park a beat in slot 0, then assert reset mid-cycle with in_valid high.
        reset_n    = 1'b1;
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h5A, 1'b1);
        tick();
        chk("pre_rst_out0_valid", out0_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_out0_valid", out0_valid, 0);
        chk("async_out0_data", out0_data, 0);
        chk("async_in_ready", in_ready, 0);
        #3 reset_n = 1'b1;
        out0_ready = 1'b1;
        drive(1'b1, 1'b1, 8'hA5, 1'b1);
        chk("rel_in_ready", in_ready, 1);
        tick();
        chk("rel_out1_valid", out1_valid, 1);
        chk("rel_out1_data", out1_data, 8'hA5);
        chk("rel_out1_last", out1_last, 1);
        chk("rel_out0_valid", out0_valid, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("rel_out1_drained", out1_valid, 0);

        // Lock holds route: 4 beats to out0 while in_sel toggles on beats 2-4.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, W'(k), (k == 4));
            chk("lock_in_ready", in_ready, 1);
            tick();
            chk("lock_out0_valid", out0_valid, 1);
            chk("lock_out0_data", out0_data, k);
            chk("lock_out0_last", out0_last, (k == 4) ? 1 : 0);
            chk("lock_out1_valid", out1_valid, 0);
            chk("lock_busy", busy, (k < 4) ? 1 : 0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("lock_drained", out0_valid, 0);

        // Backpressure on out1 across a 2-beat packet.
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h21, 1'b0);
        chk("bp_b1_in_ready", in_ready, 1);
        tick();
        chk("bp_b1_out1_data", out1_data, 8'h21);
        chk("bp_b1_busy", busy, 1);
        drive(1'b1, 1'b0, 8'h22, 1'b1);
        chk("bp_stall_in_ready", in_ready, 0);
        tick();
        chk("bp_hold_out1_valid", out1_valid, 1);
        chk("bp_hold_out1_data", out1_data, 8'h21);
        chk("bp_hold_out1_last", out1_last, 0);
        chk("bp_hold_busy", busy, 1);
        chk("bp_hold_out0_valid", out0_valid, 0);
        out1_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_b2_out1_valid", out1_valid, 1);
        chk("bp_b2_out1_data", out1_data, 8'h22);
        chk("bp_b2_out1_last", out1_last, 1);
        chk("bp_b2_busy", busy, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("bp_drained", out1_valid, 0);

        // Independent drain: out0 stalled full while out1 delivers.
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h33, 1'b1);
        tick();
        chk("ind_out0_data", out0_data, 8'h33);
        drive(1'b1, 1'b1, 8'h44, 1'b1);
        chk("ind_in_ready", in_ready, 1);
        tick();
        chk("ind_out1_valid", out1_valid, 1);
        chk("ind_out1_data", out1_data, 8'h44);
        chk("ind_out0_valid", out0_valid, 1);
        chk("ind_out0_kept", out0_data, 8'h33);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("ind_out1_drained", out1_valid, 0);
        chk("ind_out0_still", out0_valid, 1);
        chk("ind_out0_still_data", out0_data, 8'h33);
        out0_ready = 1'b1;
        tick();
        chk("ind_out0_drained", out0_valid, 0);

        // Back-to-back single-beat packets alternating route.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k[0], W'(8'h10 + k), 1'b1);
            chk("b2b_in_ready", in_ready, 1);
            tick();
            if (k[0]) begin
                chk("b2b_out1_valid", out1_valid, 1);
                chk("b2b_out1_data", out1_data, 8'h10 + k);
                chk("b2b_out0_idle", out0_valid, 0);
            end else begin
                chk("b2b_out0_valid", out0_valid, 1);
                chk("b2b_out0_data", out0_data, 8'h10 + k);
                chk("b2b_out1_idle", out1_valid, 0);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();

        // Reset while locked to out1; next packet follows in_sel.
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        tick();
        chk("mid_busy_locked", busy, 1);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out1_valid", out1_valid, 0);
        #3 reset_n = 1'b1;
        drive(1'b1, 1'b0, 8'h66, 1'b1);
        chk("mid_in_ready", in_ready, 1);
        tick();
        chk("mid_out0_valid", out0_valid, 1);
        chk("mid_out0_data", out0_data, 8'h66);
        chk("mid_out1_valid", out1_valid, 0);
        chk("mid_busy", busy, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
